// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared definitions for the convolutional encoder and the Viterbi decoder.
// Holds:
//   - default constraint length and generator polynomials (K=3, 7/5 octal);
//   - the encoder state type (IDLE, ENCODE, FLUSH);
//   - parity(): XOR-reduction of a window masked by a generator polynomial.
//     It is also used by the decoder's branch-metric and expected-symbol
//     logic. Both arguments are right-aligned in K_MAX bits, so callers
//     zero-extend narrower windows and polynomials before calling it.
package viterbi_pkg;

    localparam int         K_MAX      = 7;
    localparam int         K_DEFAULT  = 3;
    localparam logic [2:0] G0_DEFAULT = 3'b111;
    localparam logic [2:0] G1_DEFAULT = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        FLUSH  = 2'd2
    } enc_state_t;

    function automatic logic parity(input logic [K_MAX-1:0] window,
                                    input logic [K_MAX-1:0] poly);
        return ^(window & poly);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core
// Shift register plus the combinational window/parity logic of a rate-1/2
// feedforward convolutional encoder.
// Ports:
//   clk       clock; sr updates on its rising edge
//   rst       synchronous active-high reset, clears sr
//   cur_bit   bit presented to the window this cycle (data or tail zero)
//   shift_en  shift cur_bit into sr at the next edge
//   clear     force sr to zero at the next edge (takes priority over shift)
//   pair      {G0 parity, G1 parity} of window {cur_bit, sr}
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int           K  = K_DEFAULT,
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cur_bit,
    input  logic       shift_en,
    input  logic       clear,
    output logic [1:0] pair
);

    // sr_reg[K-2] is the most recent bit, sr_reg[0] the oldest.
    logic [K-2:0] sr_reg;
    logic [K-2:0] sr_shifted;
    logic [K-1:0] window;

    assign window = {cur_bit, sr_reg};

    // Shift towards index 0; the new bit enters at the top.
    generate
        for (genvar gi = 0; gi < K - 2; gi++) begin : g_shift
            assign sr_shifted[gi] = sr_reg[gi+1];
        end
    endgenerate
    assign sr_shifted[K-2] = cur_bit;

    assign pair[1] = parity(K_MAX'(window), K_MAX'(G0));
    assign pair[0] = parity(K_MAX'(window), K_MAX'(G1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr_reg <= '0;
        end else if (shift_en) begin
            sr_reg <= sr_shifted;
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder
// Rate-1/2 feedforward convolutional encoder with valid/ready handshakes on
// both sides and a single output register (latency 1, full throughput).
// Ports:
//   clk        sole clock
//   rst        synchronous active-high reset
//   in_valid   in_bit/in_last valid
//   in_ready   encoder accepts an input bit this cycle
//   in_bit     information bit
//   in_last    final information bit of a frame
//   out_valid  out_pair/out_last valid
//   out_ready  downstream accepts the pair
//   out_pair   {G0 parity, G1 parity}
//   out_last   final coded pair of a frame
//   busy       high in ENCODE or FLUSH
// Build option CONV_ENC_TAIL_FLUSH_EN:
//   defined   - after in_last, K-1 zero tail bits are encoded and out_last
//               marks the last tail pair (frame of N bits -> N+K-1 pairs).
//   undefined - no tail; out_last accompanies the in_last pair and sr is
//               cleared on that accept (frame of N bits -> N pairs).
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int           K  = K_DEFAULT,
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       busy
);

    enc_state_t state_reg, state_next;
    logic       out_valid_reg, out_valid_next;
    logic [1:0] out_pair_reg, out_pair_next;
    logic       out_last_reg, out_last_next;

    logic       load_en;
    logic       accept;
    logic       flush_step;
    logic       cur_bit;
    logic       sr_clear;
    logic       shift_en;
    logic [1:0] core_pair;

    // Output register may take a new pair when empty or being drained.
    assign load_en  = !out_valid_reg || out_ready;
    assign in_ready = !rst && (state_reg != FLUSH) && load_en;
    assign accept   = in_valid && in_ready;

`ifdef CONV_ENC_TAIL_FLUSH_EN
    localparam int           TW        = $clog2(K);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    logic [TW-1:0] tail_cnt_reg, tail_cnt_next;
    logic          tail_final;

    assign flush_step = (state_reg == FLUSH) && load_en;
    assign tail_final = (tail_cnt_reg == TAIL_LAST);
    // Tail bits are zeros; the flushed sr ends all-zero without a clear.
    assign cur_bit    = (state_reg == FLUSH) ? 1'b0 : in_bit;
    assign sr_clear   = 1'b0;
`else
    assign flush_step = 1'b0;
    assign cur_bit    = in_bit;
    // Without a tail, the next frame must still start from a zero state.
    assign sr_clear   = accept && in_last;
`endif

    assign shift_en = accept || flush_step;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .cur_bit  (cur_bit),
        .shift_en (shift_en),
        .clear    (sr_clear),
        .pair     (core_pair)
    );

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_pair_next  = out_pair_reg;
        out_last_next  = out_last_reg;
`ifdef CONV_ENC_TAIL_FLUSH_EN
        tail_cnt_next  = tail_cnt_reg;
`endif

        // Pair handed downstream; pair/last keep their last value.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            out_valid_next = 1'b1;
            out_pair_next  = core_pair;
`ifdef CONV_ENC_TAIL_FLUSH_EN
            out_last_next  = 1'b0;
            state_next     = in_last ? FLUSH : ENCODE;
            tail_cnt_next  = '0;
`else
            out_last_next  = in_last;
            state_next     = in_last ? IDLE : ENCODE;
`endif
        end
`ifdef CONV_ENC_TAIL_FLUSH_EN
        else if (flush_step) begin
            out_valid_next = 1'b1;
            out_pair_next  = core_pair;
            out_last_next  = tail_final;
            if (tail_final) begin
                state_next    = IDLE;
                tail_cnt_next = '0;
            end else begin
                tail_cnt_next = tail_cnt_reg + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_pair_reg  <= 2'b00;
            out_last_reg  <= 1'b0;
`ifdef CONV_ENC_TAIL_FLUSH_EN
            tail_cnt_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_pair_reg  <= out_pair_next;
            out_last_reg  <= out_last_next;
`ifdef CONV_ENC_TAIL_FLUSH_EN
            tail_cnt_reg  <= tail_cnt_next;
`endif
        end
    end

    assign out_valid = out_valid_reg;
    assign out_pair  = out_pair_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder
// Scoreboard bench for conv_encoder (K=3, G0=111, G1=101). Expected
// {pair,last} entries are queued when an input bit is accepted (directed
// tables or a reference encoder) and popped whenever a pair is handed
// downstream. Works with CONV_ENC_TAIL_FLUSH_EN defined or undefined.
module tb_conv_encoder;

    localparam int         K  = 3;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_pair;
    logic       out_last;
    logic       busy;

    conv_encoder #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_pair = 0;
    int           cyc = 0;
    int           rdy_mode = 0;
    bit           use_model = 0;
    bit           accepted = 0;
    bit           stall_pend = 0;
    logic         rst_req = 1'b1;
    logic [2:0]   held;
    logic [K-2:0] msr = '0;
    logic [2:0]   sb[$];

`ifdef CONV_ENC_TAIL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_pair(input logic b);
        logic [K-1:0] w;
        w = {b, msr};
        return {^(w & G0), ^(w & G1)};
    endfunction

    task automatic push(input logic [1:0] p, input logic l);
        sb.push_back({p, l});
    endtask

    task automatic model_accept(input logic b, input logic l);
        if (!use_model) return;
        push(model_pair(b), FLUSH_EN ? 1'b0 : l);
        msr = {b, msr[K-2:1]};
        if (l) begin
            if (FLUSH_EN) begin
                for (int t = 0; t < K - 1; t++) begin
                    push(model_pair(1'b0), t == K - 2);
                    msr = {1'b0, msr[K-2:1]};
                end
            end else begin
                msr = '0;
            end
        end
    endtask

    // Called #1 after each falling edge: decides what the next rising edge
    // will transfer and checks the held-stall behaviour.
    task automatic observe();
        logic [2:0] e;
        accepted = 0;
        if (rst) begin
            stall_pend = 0;
            return;
        end
        if (stall_pend) begin
            check("stall_hold", {29'd0, out_pair, out_last}, {29'd0, held});
            stall_pend = 0;
        end
        if (out_valid && !out_ready) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            held = {out_pair, out_last};
            stall_pend = 1;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra_pair", {29'd0, out_pair, out_last}, 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                check($sformatf("pair%0d", n_pair), {29'd0, out_pair, out_last}, {29'd0, e});
                $display("pair %0d: got %b last %b exp %b last %b", n_pair, out_pair, out_last, e[2:1], e[0]);
                n_pair++;
            end
        end
        if (in_valid && in_ready) begin
            accepted = 1;
            model_accept(in_bit, in_last);
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic l);
        @(negedge clk);
        rst       = rst_req;
        in_valid  = v;
        in_bit    = b;
        in_last   = l;
        out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        cyc++;
        #1;
        observe();
    endtask

    task automatic drive_bit(input logic b, input logic l);
        int t;
        for (t = 0; t < 100; t++) begin
            cycle(1'b1, b, l);
            if (accepted) break;
        end
        if (t == 100) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_frame(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) drive_bit(bits[i], i == n - 1);
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 60 && (sb.size() != 0 || out_valid || busy); t++) cycle(1'b0, 1'b0, 1'b0);
        check("drain_sb_empty", sb.size(), 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    // Frame 1,0,1,1 as listed, lsb first in the vector.
    task automatic push_frame4();
        push(2'b11, 1'b0);
        push(2'b10, 1'b0);
        push(2'b00, 1'b0);
        if (FLUSH_EN) begin
            push(2'b01, 1'b0);
            push(2'b01, 1'b0);
            push(2'b11, 1'b1);
        end else begin
            push(2'b01, 1'b1);
        end
    endtask

    task automatic push_single();
        if (FLUSH_EN) begin
            push(2'b11, 1'b0);
            push(2'b10, 1'b0);
            push(2'b11, 1'b1);
        end else begin
            push(2'b11, 1'b1);
        end
    endtask

    task automatic random_run(input int total, input int mode);
        int start, nbits, nfr, len, cycles;
        rdy_mode  = mode;
        use_model = 1;
        msr       = '0;
        nbits     = 0;
        nfr       = 0;
        start     = cyc;
        while (nbits < total) begin
            len = $urandom_range(1, 24);
            if (nbits + len > total) len = total - nbits;
            for (int i = 0; i < len; i++) drive_bit(logic'($urandom_range(0, 1)), i == len - 1);
            nbits += len;
            nfr++;
        end
        cycles = cyc - start;
        if (mode == 0)
            check("b2b_cycles", cycles, total + (FLUSH_EN ? (nfr - 1) * (K - 1) : 0));
        drain();
        use_model = 0;
        rdy_mode  = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        // Reset behaviour
        rst_req = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_req = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("rst_state", {27'd0, out_valid, out_pair, out_last, busy}, 32'd0);

        // Frame 1,0,1,1 at full rate
        push_frame4();
        drive_frame(32'b1101, 4);
        drain();

        // Single-bit frame
        push_single();
        drive_frame(32'b1, 1);
        drain();

        // Same frame with out_ready pattern 1,0,0,...
        rdy_mode = 1;
        push_frame4();
        drive_frame(32'b1101, 4);
        drain();
        rdy_mode = 0;

        // Reset in the middle of a frame or flush, then a fresh frame
        if (FLUSH_EN) begin
            push(2'b11, 1'b0); push(2'b10, 1'b0); push(2'b00, 1'b0); push(2'b01, 1'b0);
            drive_frame(32'b1101, 4);
            cycle(1'b0, 1'b0, 1'b0);
            rst_req = 1'b1;
            cycle(1'b0, 1'b0, 1'b0);
            check("flush_tail1", {27'd0, out_valid, out_pair, out_last, busy}, 32'b1_01_0_1);
        end else begin
            push(2'b11, 1'b0); push(2'b10, 1'b0);
            drive_bit(1'b1, 1'b0);
            drive_bit(1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            rst_req = 1'b1;
            cycle(1'b0, 1'b0, 1'b0);
        end
        rst_req = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("midrst_state", {27'd0, out_valid, out_pair, out_last, busy}, 32'd0);
        check("midrst_sb_empty", sb.size(), 32'd0);
        push_single();
        drive_frame(32'b1, 1);
        drain();

        // Two frames back to back: second must start from a zero state
        push_frame4();
        push_frame4();
        drive_frame(32'b1101, 4);
        drive_frame(32'b1101, 4);
        drain();

        // Random back-to-back frames against the reference encoder
        random_run(1000, 0);
        random_run(200, 1);

        check("final_sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- K, 3, constraint length (3..7).
- G0, 3'b111, generator polynomial for out_pair[1]; K bits wide, MSB taps the current input bit.
- G1, 3'b101, generator polynomial for out_pair[0]; K bits wide, same bit order as G0.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit/in_last valid.
- in_ready  output  1  encoder accepts an input bit this cycle.
- in_bit  input  1  information bit.
- in_last  input  1  marks the final information bit of a frame.
- out_valid  output  1  out_pair/out_last valid.
- out_ready  input  1  downstream (channel/decoder) accepts the pair.
- out_pair  output  2  coded symbol pair {G0 parity, G1 parity}.
- out_last  output  1  marks the final coded pair of a frame.
- busy  output  1  high in ENCODE or FLUSH state.

Function
REQ-003 Rate-1/2 feedforward encoder; shift register sr[K-2:0] holds previous input bits, sr[K-2] the most recent.
REQ-004 Window w SHALL be {in_bit, sr[K-2:0]}; out_pair[1] = XOR-reduce(w & G0); out_pair[0] = XOR-reduce(w & G1).
REQ-005 On accept (in_valid && in_ready) sr SHALL become {in_bit, sr[K-2:1]}.
REQ-006 Output stage SHALL be a single register; a coded pair appears one cycle after the accepting edge (latency 1).
REQ-007 in_ready SHALL equal (state != FLUSH) && (!out_valid || out_ready); full throughput of one pair per cycle SHALL be sustained while out_ready stays high.
REQ-008 While out_valid && !out_ready, out_pair and out_last SHALL hold stable; no pair SHALL be dropped or duplicated.
REQ-009 FSM states SHALL be IDLE, ENCODE and FLUSH.
- IDLE -> ENCODE on an accept without in_last.
- IDLE or ENCODE -> FLUSH on an accept with in_last.
- FLUSH -> IDLE after the final tail pair is loaded into the output register.
REQ-010 In FLUSH the encoder SHALL feed K-1 internal zero bits, one per cycle in which the output register can load, using a tail counter of width clog2(K).
REQ-011 out_last SHALL be set on the pair produced by the final tail bit only; sr SHALL be all-zero on return to IDLE.
REQ-012 A single-bit frame (in_last on the first bit) SHALL produce exactly K pairs.
REQ-013 In FLUSH, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-014 in_last SHALL be ignored unless in_valid && in_ready.

Reset
REQ-015 When rst is high at a clock edge, the following SHALL hold after that edge, regardless of state:
- state = IDLE, sr = 0, tail counter = 0.
- out_valid = 0, out_pair = 2'b00, out_last = 0, busy = 0.
REQ-016 Reset mid-frame or mid-flush SHALL discard the pending frame without emitting out_last.
REQ-017 While rst is high, in_ready SHALL be 0.

Configuration
REQ-018 Macro CONV_ENC_TAIL_FLUSH_EN SHALL control tail termination.
- Defined: REQ-010 to REQ-012 apply as written.
- Undefined: no FLUSH state; out_last accompanies the pair for the in_last bit; sr clears to zero on that accept; the encoder returns to IDLE; a frame of N bits yields exactly N pairs.

Structure
REQ-019 Shared package viterbi_pkg SHALL hold:
- default K, G0 and G1 constants;
- the encoder state enum type (IDLE, ENCODE, FLUSH);
- a parity function (window, polynomial) -> bit, shared with the decoder's branch-metric and expected-symbol logic.
REQ-020 One sub-module, conv_enc_core, SHALL be used: combinational window/parity logic plus the sr register; the FSM and output handshake stay in conv_encoder.

Verification
REQ-021 Directed scenarios the bench SHALL cover (defaults K=3, G0=111, G1=101, flush enabled unless stated):
- Bits 1,0,1,1 (last on 4th), out_ready=1 -> pairs 11,10,00,01,01,11; out_last only on the 6th pair.
- Single bit 1 with in_last -> pairs 11,10,11; out_last on the 3rd; busy low afterwards.
- Same 4-bit frame with out_ready toggled 1,0,0,1,... -> identical pair sequence, pairs stable while stalled, in_ready low on every stalled cycle.
- rst asserted in FLUSH after 1 tail pair -> next cycle out_valid=0, state IDLE; a new frame 1 (last) gives 11,10,11.
- Macro undefined, frame 1,0,1,1 -> pairs 11,10,00,01; out_last on the 4th; next frame starts from sr=0.
- Back-to-back frames with in_valid held high -> no bubble except K-1 flush cycles; all pairs match a reference model over 1000 random bits.
